// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO family.
package fifo_pkg;

    localparam int FIFO_MAX_DEPTH_LOG2 = 8;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

    // Count needs one extra bit so that DEPTH itself is representable.
    function automatic int fifo_cnt_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// WIDTH x 2**DEPTH_LOG2 register array: one synchronous write port, one asynchronous read port.
module sync_fifo_mem #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for show-ahead (first-word-fall-through) reads.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_LEVEL   = 2 ** DEPTH_LOG2 - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  read,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = fifo_cnt_w(DEPTH_LOG2);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo: WIDTH must be >= 1");
    end
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > FIFO_MAX_DEPTH_LOG2) begin : g_bad_depth
        $error("sync_fifo: DEPTH_LOG2 out of range");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL) begin : g_bad_ae
        $error("sync_fifo: AE_LEVEL out of range");
    end

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [WIDTH-1:0]      mem_rdata;
    fifo_status_t          status;

    // Flags decode from the registered count only, never from this cycle's requests.
    always_comb begin
        status              = '0;
        status.empty        = (cnt == '0);
        status.full         = (cnt == CNT_W'(DEPTH));
        status.almost_empty = (cnt <= CNT_W'(AE_LEVEL));
        status.almost_full  = (cnt >= CNT_W'(AF_LEVEL));
    end

    assign empty        = status.empty;
    assign full         = status.full;
    assign almost_empty = status.almost_empty;
    assign almost_full  = status.almost_full;
    assign count        = cnt;

    assign rd_acc = read & ~status.empty;
    assign wr_acc = write & (~status.full | rd_acc);

    sync_fifo_mem #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            cnt       <= cnt + CNT_W'(wr_acc) - CNT_W'(rd_acc);
            // A new error event takes priority over a coincident clear.
            overflow  <= (write & ~wr_acc) | (overflow & ~clr_err);
            underflow <= (read & status.empty) | (underflow & ~clr_err);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown directly; gated while empty so stale storage never leaks out.
    assign rd_data  = status.empty ? '0 : mem_rdata;
    assign rd_valid = ~status.empty;
`else
    logic [WIDTH-1:0] rd_data_r;
    logic             rd_valid_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_acc;
            if (rd_acc)
                rd_data_r <= mem_rdata;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo;

    localparam int WIDTH      = 8;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;
    localparam int AF_LEVEL   = 3;
    localparam int AE_LEVEL   = 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                write;
    logic [WIDTH-1:0]    wr_data;
    logic                read;
    logic                clr_err;
    logic [WIDTH-1:0]    rd_data;
    logic                rd_valid;
    logic                empty;
    logic                full;
    logic                almost_empty;
    logic                almost_full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                underflow;

    sync_fifo #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .AF_LEVEL   (AF_LEVEL),
        .AE_LEVEL   (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .write        (write),
        .wr_data      (wr_data),
        .read         (read),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model: contents as a queue, plus the visible read-side state.
    logic [WIDTH-1:0] q[$];
    logic             m_ovf;
    logic             m_unf;
    logic [WIDTH-1:0] m_rd_data;
    logic             m_rd_valid;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        int unsigned n;
        n = q.size();
        check_eq("count",        32'(count),        32'(n));
        check_eq("empty",        32'(empty),        32'(n == 0));
        check_eq("full",         32'(full),         32'(n == DEPTH));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE_LEVEL));
        check_eq("almost_full",  32'(almost_full),  32'(n >= AF_LEVEL));
        check_eq("overflow",     32'(overflow),     32'(m_ovf));
        check_eq("underflow",    32'(underflow),    32'(m_unf));
        check_eq("rd_valid",     32'(rd_valid),     32'(m_rd_valid));
        check_eq("rd_data",      32'(rd_data),      32'(m_rd_data));
    endtask

    // One clock: apply requests, advance model by the FIFO's accept rules, compare.
    task automatic step(input logic w, input logic [WIDTH-1:0] wd, input logic r,
                        input logic clr, input logic rst);
        bit was_empty, was_full, racc, wacc;
        write   = w;
        wr_data = wd;
        read    = r;
        clr_err = clr;
        reset   = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            m_rd_valid = 1'b0;
            m_rd_data  = '0;
        end else begin
            was_empty = (q.size() == 0);
            was_full  = (q.size() == DEPTH);
            racc = r && !was_empty;
            wacc = w && (!was_full || racc);
            m_ovf = (w && !wacc) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            m_unf = (r && was_empty) ? 1'b1 : (clr ? 1'b0 : m_unf);
`ifndef SYNC_FIFO_FWFT_EN
            m_rd_valid = racc;
            if (racc)
                m_rd_data = q[0];
`endif
            if (racc)
                void'(q.pop_front());
            if (wacc)
                q.push_back(wd);
        end
`ifdef SYNC_FIFO_FWFT_EN
        m_rd_valid = (q.size() != 0);
        m_rd_data  = (q.size() != 0) ? q[0] : '0;
`endif
        check_all();
        write   = 1'b0;
        read    = 1'b0;
        clr_err = 1'b0;
        reset   = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] fill_vals [4];
        bit wr_bias;
        fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        write = 1'b0; read = 1'b0; clr_err = 1'b0; reset = 1'b1; wr_data = '0;
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;

        // Reset state
        step(0, '0, 0, 0, 1);
        step(0, '0, 0, 0, 1);

        // Fill, overflow, drain, clear
        for (int i = 0; i < 4; i++) step(1, fill_vals[i], 0, 0, 0);
        step(1, 8'h55, 0, 0, 0);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        check_eq("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous read/write, then drain across pointer wrap
        for (int i = 0; i < 4; i++) step(1, fill_vals[i], 0, 0, 0);
        step(1, 8'h66, 1, 0, 0);
        check_eq("full_rw_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0);
        step(0, '0, 0, 0, 0);

        // Empty with simultaneous read/write
        step(1, 8'h77, 1, 0, 0);
        check_eq("empty_rw_unf", 32'(underflow), 32'd1);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 1, 0);

        // Reset mid-operation, then a read must underflow
        for (int i = 0; i < 3; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);
        step(1, 8'h5A, 1, 0, 1);
        check_eq("rst_count", 32'(count), 32'd0);
        step(0, '0, 1, 0, 0);
        check_eq("rst_read_unf", 32'(underflow), 32'd1);
        step(0, '0, 0, 1, 0);

        // Show-ahead visibility (also meaningful in registered mode via the model)
        step(1, 8'hA5, 0, 0, 0);
        step(0, '0, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(0, '0, 0, 0, 0);

        // Random traffic with phases biased toward filling or draining
        wr_bias = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0)
                wr_bias = ($urandom_range(0, 1) == 1);
            step(($urandom_range(0, 99) < (wr_bias ? 75 : 30)),
                 8'($urandom),
                 ($urandom_range(0, 99) < (wr_bias ? 30 : 75)),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
